// File: rtl/ll_pkg.sv
// Shared types and constants for the linked-list pointer server.
package ll_pkg;
  localparam int PTR_WD    = 4;
  localparam int NUM_NODES = (1 << PTR_WD) - 1;

  typedef logic [PTR_WD-1:0] t_ptr;

  // All-ones pointer marks end-of-list / empty head and tail.
  localparam t_ptr NULL_PTR = '1;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    LINK,
    TERM
  } t_ptr_srv_st;
endpackage

// File: rtl/ll_free_ptr_fifo.sv
// Free-pointer pool: circular FIFO of node pointers with a
// first-word-fall-through head. Indices wrap modulo the depth.
module ll_free_ptr_fifo
  import ll_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  t_ptr              push_ptr,
  input  logic              pop,
  output t_ptr              head_ptr,
  output logic [PTR_WD:0]   count,
  output logic              empty,
  output logic              full
);
  localparam int              DEPTH     = 1 << PTR_WD;
  localparam logic [PTR_WD:0] DEPTH_CNT = (PTR_WD+1)'(DEPTH);

  t_ptr            mem_q [DEPTH];
  t_ptr            wr_idx_q, wr_idx_d;
  t_ptr            rd_idx_q, rd_idx_d;
  logic [PTR_WD:0] cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == DEPTH_CNT);
  assign count    = cnt_q;
  assign head_ptr = mem_q[rd_idx_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  // Next index and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_idx_d = wr_idx_q + PTR_WD'(1);
    if (pop_ok)  rd_idx_d = rd_idx_q + PTR_WD'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (PTR_WD+1)'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - (PTR_WD+1)'(1);
  end

  // Index and count registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx_q] <= push_ptr;
  end
endmodule

// File: rtl/ll_nxt_ptr_server.sv
// Linked-list pointer server: hands out free node pointers, links them at
// the tail, pops the head back into the free pool, and offers a registered
// traversal read of the next-pointer memory.
module ll_nxt_ptr_server
  import ll_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              upd_nxt_ptr,
  input  logic [PTR_WD-1:0] cur_nxt_ptr,
  output logic [PTR_WD-1:0] nxt_ptr_from_servr,
  output logic              ptr_avail,
  output logic              nxt_ptr_wr_done,
  input  logic              pop_head_req,
  output logic              pop_rdy,
  output logic [PTR_WD-1:0] head_ptr,
  output logic [PTR_WD-1:0] tail_ptr,
  output logic              list_empty,
  output logic [PTR_WD:0]   free_cnt,
  input  logic [PTR_WD-1:0] rd_addr,
  output logic [PTR_WD-1:0] rd_nxt_ptr,
  output logic              init_done,
  output logic              alloc_err,
  output logic              pop_err
);
  t_ptr_srv_st st_q, st_d;
  t_ptr        init_cnt_q, init_cnt_d;
  t_ptr        head_q, head_d;
  t_ptr        tail_q, tail_d;
  t_ptr        alloc_ptr_q, alloc_ptr_d;
  t_ptr        rd_nxt_ptr_q, rd_nxt_ptr_d;
  logic        list_empty_q, list_empty_d;
  logic        init_done_q, init_done_d;
  logic        wr_done_q, wr_done_d;
  logic        alloc_err_q, alloc_err_d;
  logic        pop_err_q, pop_err_d;
  logic        pop_rdy_c;

  t_ptr        nxt_mem_q [1 << PTR_WD];
  logic        mem_we;
  t_ptr        mem_waddr, mem_wdata;

  logic            fifo_push, fifo_pop;
  t_ptr            fifo_push_ptr, fifo_head;
  logic [PTR_WD:0] fifo_cnt;
  logic            fifo_empty, fifo_full;
  logic            ptr_avail_c;

  ll_free_ptr_fifo u_free_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_ptr (fifo_push_ptr),
    .pop      (fifo_pop),
    .head_ptr (fifo_head),
    .count    (fifo_cnt),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign ptr_avail_c        = init_done_q & ~fifo_empty;
  assign ptr_avail          = ptr_avail_c;
  assign nxt_ptr_from_servr = ptr_avail_c ? fifo_head : '0;
  assign nxt_ptr_wr_done    = wr_done_q;
  assign pop_rdy            = pop_rdy_c;
  assign head_ptr           = head_q;
  assign tail_ptr           = tail_q;
  assign list_empty         = list_empty_q;
  assign free_cnt           = fifo_cnt;
  assign rd_nxt_ptr         = rd_nxt_ptr_q;
  assign init_done          = init_done_q;
  assign alloc_err          = alloc_err_q;
  assign pop_err            = pop_err_q;

  // Next-state, free-pool control and next-pointer memory write selection.
  always_comb begin
    st_d          = st_q;
    init_cnt_d    = init_cnt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    alloc_ptr_d   = alloc_ptr_q;
    list_empty_d  = list_empty_q;
    init_done_d   = init_done_q;
    wr_done_d     = wr_done_q;
    alloc_err_d   = 1'b0;
    pop_err_d     = 1'b0;
    pop_rdy_c     = 1'b0;
    fifo_push     = 1'b0;
    fifo_push_ptr = init_cnt_q;
    fifo_pop      = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = tail_q;
    mem_wdata     = alloc_ptr_q;
    rd_nxt_ptr_d  = nxt_mem_q[rd_addr];

    case (st_q)
      INIT: begin
        // Seed the pool with every non-NULL pointer, one per cycle.
        fifo_push     = ~fifo_full;
        fifo_push_ptr = init_cnt_q;
        init_cnt_d    = init_cnt_q + PTR_WD'(1);
        alloc_err_d   = upd_nxt_ptr;
        pop_err_d     = pop_head_req;
        if (init_cnt_q == t_ptr'(NUM_NODES - 1)) begin
          init_done_d = 1'b1;
          st_d        = IDLE;
        end
      end
      IDLE: begin
        // Allocation outranks pop; a blocked pop is simply held by its requester.
        if (upd_nxt_ptr) begin
          if (ptr_avail_c && (cur_nxt_ptr == fifo_head)) begin
            fifo_pop    = 1'b1;
            alloc_ptr_d = cur_nxt_ptr;
            wr_done_d   = 1'b0;
            st_d        = LINK;
          end else begin
            alloc_err_d = 1'b1;
          end
        end else if (pop_head_req) begin
          if (!list_empty_q) begin
            pop_rdy_c     = 1'b1;
            fifo_push     = 1'b1;
            fifo_push_ptr = head_q;
            if (head_q == tail_q) begin
              head_d       = NULL_PTR;
              tail_d       = NULL_PTR;
              list_empty_d = 1'b1;
            end else begin
              head_d = nxt_mem_q[head_q];
            end
          end else begin
            pop_err_d = 1'b1;
          end
        end
      end
      LINK: begin
        // Chain the old tail to the new node.
        mem_we      = ~list_empty_q;
        mem_waddr   = tail_q;
        mem_wdata   = alloc_ptr_q;
        alloc_err_d = upd_nxt_ptr;
        st_d        = TERM;
      end
      TERM: begin
        // Terminate the new node and make it the tail.
        mem_we       = 1'b1;
        mem_waddr    = alloc_ptr_q;
        mem_wdata    = NULL_PTR;
        tail_d       = alloc_ptr_q;
        if (list_empty_q) head_d = alloc_ptr_q;
        list_empty_d = 1'b0;
        wr_done_d    = 1'b1;
        alloc_err_d  = upd_nxt_ptr;
        st_d         = IDLE;
      end
      default: st_d = INIT;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q         <= INIT;
      init_cnt_q   <= '0;
      head_q       <= NULL_PTR;
      tail_q       <= NULL_PTR;
      list_empty_q <= 1'b1;
      init_done_q  <= 1'b0;
      wr_done_q    <= 1'b0;
      alloc_err_q  <= 1'b0;
      pop_err_q    <= 1'b0;
      rd_nxt_ptr_q <= NULL_PTR;
    end else begin
      st_q         <= st_d;
      init_cnt_q   <= init_cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      list_empty_q <= list_empty_d;
      init_done_q  <= init_done_d;
      wr_done_q    <= wr_done_d;
      alloc_err_q  <= alloc_err_d;
      pop_err_q    <= pop_err_d;
      rd_nxt_ptr_q <= rd_nxt_ptr_d;
    end
  end

  // Pointer captured at allocation; only consumed in LINK/TERM, so unreset.
  always_ff @(posedge clk) begin
    alloc_ptr_q <= alloc_ptr_d;
  end

  // Next-pointer memory write port.
  always_ff @(posedge clk) begin
    if (mem_we) nxt_mem_q[mem_waddr] <= mem_wdata;
  end
endmodule

// File: tb/tb_ll_nxt_ptr_server.sv
// Bench for ll_nxt_ptr_server: directed scenarios plus a random mix of
// allocate / pop / traverse, compared against a queue-based list model.
module tb_ll_nxt_ptr_server;
  localparam int NUL = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       upd_nxt_ptr;
  logic [3:0] cur_nxt_ptr;
  logic [3:0] nxt_ptr_from_servr;
  logic       ptr_avail;
  logic       nxt_ptr_wr_done;
  logic       pop_head_req;
  logic       pop_rdy;
  logic [3:0] head_ptr;
  logic [3:0] tail_ptr;
  logic       list_empty;
  logic [4:0] free_cnt;
  logic [3:0] rd_addr;
  logic [3:0] rd_nxt_ptr;
  logic       init_done;
  logic       alloc_err;
  logic       pop_err;

  int n_cmp = 0;
  int n_bad = 0;

  int free_q[$];
  int list_q[$];
  bit done_m;

  always #5 clk = ~clk;

  ll_nxt_ptr_server dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .upd_nxt_ptr        (upd_nxt_ptr),
    .cur_nxt_ptr        (cur_nxt_ptr),
    .nxt_ptr_from_servr (nxt_ptr_from_servr),
    .ptr_avail          (ptr_avail),
    .nxt_ptr_wr_done    (nxt_ptr_wr_done),
    .pop_head_req       (pop_head_req),
    .pop_rdy            (pop_rdy),
    .head_ptr           (head_ptr),
    .tail_ptr           (tail_ptr),
    .list_empty         (list_empty),
    .free_cnt           (free_cnt),
    .rd_addr            (rd_addr),
    .rd_nxt_ptr         (rd_nxt_ptr),
    .init_done          (init_done),
    .alloc_err          (alloc_err),
    .pop_err            (pop_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".head"},  head_ptr, (list_q.size() > 0) ? list_q[0] : NUL);
    chk({tag, ".tail"},  tail_ptr, (list_q.size() > 0) ? list_q[$] : NUL);
    chk({tag, ".empty"}, list_empty, list_q.size() == 0);
    chk({tag, ".free"},  free_cnt, free_q.size());
    chk({tag, ".avail"}, ptr_avail, free_q.size() > 0);
    if (free_q.size() > 0) chk({tag, ".served"}, nxt_ptr_from_servr, free_q[0]);
    chk({tag, ".done"},  nxt_ptr_wr_done, done_m);
  endtask

  task automatic do_reset();
    int n;
    reset_n = 1'b0; upd_nxt_ptr = 1'b0; pop_head_req = 1'b0;
    cur_nxt_ptr = '0; rd_addr = '0;
    repeat (2) tick();
    chk("rst.head",  head_ptr, NUL);
    chk("rst.tail",  tail_ptr, NUL);
    chk("rst.rd",    rd_nxt_ptr, NUL);
    chk("rst.empty", list_empty, 1);
    chk("rst.free",  free_cnt, 0);
    chk("rst.init",  init_done, 0);
    chk("rst.avail", ptr_avail, 0);
    chk("rst.srv",   nxt_ptr_from_servr, 0);
    chk("rst.done",  nxt_ptr_wr_done, 0);
    chk("rst.aerr",  alloc_err, 0);
    chk("rst.perr",  pop_err, 0);
    reset_n = 1'b1;
    free_q.delete(); list_q.delete(); done_m = 1'b0;
    n = 0;
    while (!init_done && n < 40) begin
      if (n == 3) begin upd_nxt_ptr = 1'b1; pop_head_req = 1'b1; end
      tick();
      n++;
      if (n == 4) begin
        chk("init.aerr", alloc_err, 1);
        chk("init.perr", pop_err, 1);
        upd_nxt_ptr = 1'b0; pop_head_req = 1'b0;
      end
    end
    chk("init.latency", n, 15);
    for (int i = 0; i < 15; i++) free_q.push_back(i);
    check_state("init");
  endtask

  task automatic alloc(input bit good_cur);
    int  exp_ptr;
    bit  ok;
    exp_ptr = (free_q.size() > 0) ? free_q[0] : 0;
    ok = good_cur && (free_q.size() > 0);
    if (good_cur) cur_nxt_ptr = 4'(exp_ptr);
    else          cur_nxt_ptr = 4'(exp_ptr) ^ 4'($urandom_range(1, 15));
    upd_nxt_ptr = 1'b1;
    tick();
    upd_nxt_ptr = 1'b0;
    chk("alloc.err", alloc_err, !ok);
    if (ok) begin
      chk("alloc.done_t1", nxt_ptr_wr_done, 0);
      tick();
      chk("alloc.done_t2", nxt_ptr_wr_done, 0);
      tick();
      chk("alloc.done_t3", nxt_ptr_wr_done, 1);
      void'(free_q.pop_front());
      list_q.push_back(exp_ptr);
      done_m = 1'b1;
    end else begin
      tick();
      chk("alloc.err_pulse", alloc_err, 0);
    end
    check_state("alloc");
  endtask

  task automatic pop();
    bit has;
    has = list_q.size() > 0;
    pop_head_req = 1'b1;
    @(negedge clk);
    chk("pop.rdy", pop_rdy, has);
    tick();
    pop_head_req = 1'b0;
    chk("pop.err", pop_err, !has);
    if (has) free_q.push_back(list_q.pop_front());
    check_state("pop");
  endtask

  task automatic rd_chk(input int idx);
    int exp;
    exp = (idx == list_q.size() - 1) ? NUL : list_q[idx + 1];
    rd_addr = 4'(list_q[idx]);
    tick();
    chk("rd.nxt", rd_nxt_ptr, exp);
  endtask

  // Allocate and pop in the same cycle; the held pop completes right after TERM.
  task automatic collide();
    int exp_ptr;
    exp_ptr = free_q[0];
    cur_nxt_ptr = 4'(exp_ptr);
    upd_nxt_ptr = 1'b1;
    pop_head_req = 1'b1;
    @(negedge clk);
    chk("coll.rdy_upd", pop_rdy, 0);
    tick();
    upd_nxt_ptr = 1'b0;
    @(negedge clk);
    chk("coll.rdy_link", pop_rdy, 0);
    tick();
    @(negedge clk);
    chk("coll.rdy_term", pop_rdy, 0);
    tick();
    chk("coll.done", nxt_ptr_wr_done, 1);
    @(negedge clk);
    chk("coll.rdy_idle", pop_rdy, 1);
    tick();
    pop_head_req = 1'b0;
    void'(free_q.pop_front());
    list_q.push_back(exp_ptr);
    done_m = 1'b1;
    free_q.push_back(list_q.pop_front());
    check_state("coll");
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Three links, then walk the chain.
    for (int i = 0; i < 3; i++) alloc(1'b1);
    for (int i = 0; i < 3; i++) rd_chk(i);

    // Drain, then confirm pool order wraps: 3..14 then 0,1,2.
    for (int i = 0; i < 3; i++) pop();
    for (int i = 0; i < 15; i++) begin
      chk("wrap.served", nxt_ptr_from_servr, (i < 12) ? i + 3 : i - 12);
      alloc(1'b1);
    end

    // Pool exhausted.
    chk("full.avail", ptr_avail, 0);
    alloc(1'b1);
    for (int i = 0; i < 15; i += 4) rd_chk(i);

    for (int i = 0; i < 5; i++) pop();
    collide();
    alloc(1'b0);

    while (list_q.size() > 0) pop();
    pop();

    // Random mix.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r <= 3)       alloc(1'b1);
      else if (r == 4)  alloc(1'b0);
      else if (r <= 8)  pop();
      else if (r == 9) begin
        if (list_q.size() > 0) rd_chk($urandom_range(0, list_q.size() - 1));
      end else begin
        if (list_q.size() > 0 && free_q.size() > 0) collide();
      end
    end

    // Reset while in LINK.
    if (free_q.size() == 0) pop();
    cur_nxt_ptr = 4'(free_q[0]);
    upd_nxt_ptr = 1'b1;
    tick();
    upd_nxt_ptr = 1'b0;
    do_reset();
    alloc(1'b1);
    alloc(1'b1);
    rd_chk(0);
    rd_chk(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ll_nxt_ptr_server.md
Name: ll_nxt_ptr_server

Overview:
- Owns linked-list pointer state:
  - pool of free node pointers;
  - next-pointer memory;
  - head and tail registers.
- Serves the next free pointer to the write controller (`nxt_ptr_from_servr`).
- On `upd_nxt_ptr`, links the served node at the tail and signals `nxt_ptr_wr_done`.
- Also services head-pop (delete) requests, which return nodes to the free pool, and a traversal read port.

Parameters:
- PTR_WD, 4, pointer width.
- NUM_NODES, 2**PTR_WD-1, usable nodes; pointer value all-ones is NULL.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- upd_nxt_ptr  in  1  one-cycle pulse from write controller: allocate and link node
- cur_nxt_ptr  in  PTR_WD  pointer being linked (must equal `nxt_ptr_from_servr` of the previous cycle)
- nxt_ptr_from_servr  out  PTR_WD  head of free pool; valid when `ptr_avail`
- ptr_avail  out  1  `init_done` & free pool non-empty
- nxt_ptr_wr_done  out  1  link complete; sticky
- pop_head_req  in  1  remove head node, return it to free pool
- pop_rdy  out  1  pop accepted this cycle
- head_ptr  out  PTR_WD  current list head (NULL when empty)
- tail_ptr  out  PTR_WD  current list tail (NULL when empty)
- list_empty  out  1  no nodes linked
- free_cnt  out  PTR_WD+1  free pool occupancy
- rd_addr  in  PTR_WD  traversal read address
- rd_nxt_ptr  out  PTR_WD  `nxt_mem[rd_addr]`, registered, 1-cycle latency
- init_done  out  1  free pool initialised
- alloc_err  out  1  one-cycle pulse: `upd_nxt_ptr` ignored
- pop_err  out  1  one-cycle pulse: pop on empty list

Behaviour:
- **Reset values:**
  - `head_ptr`, `tail_ptr`, `rd_nxt_ptr` = NULL;
  - `list_empty` = 1;
  - `free_cnt` = 0;
  - all other outputs = 0;
  - FSM = INIT;
  - nxt_mem contents don't-care.
- Reset mid-operation aborts everything and re-runs INIT.
- **INIT:**
  - Pushes pointers 0..NUM_NODES-1 into the free FIFO, one per cycle (NUM_NODES cycles).
  - On the cycle after the last push: `init_done` = 1 and FSM goes to IDLE.
  - `upd_nxt_ptr` and `pop_head_req` are ignored in INIT (`alloc_err`/`pop_err` pulse).
- **IDLE:**
  - `upd_nxt_ptr` & `ptr_avail`:
    - pop free FIFO;
    - `alloc_ptr` <= `cur_nxt_ptr`;
    - clear `nxt_ptr_wr_done`;
    - go LINK.
  - `upd_nxt_ptr` & !`ptr_avail`: `alloc_err` pulse; stay IDLE.
  - If `cur_nxt_ptr` != `nxt_ptr_from_servr`: `alloc_err` pulse, request ignored.
  - Else `pop_head_req` & !`list_empty`:
    - `pop_rdy` = 1 (combinational);
    - push `head_ptr` into free FIFO;
    - if `head_ptr` == `tail_ptr`: head, tail <= NULL and `list_empty` <= 1;
    - otherwise `head_ptr` <= `nxt_mem[head_ptr]`;
    - stay IDLE; single cycle.
  - `pop_head_req` & `list_empty`: `pop_err` pulse.
  - `upd_nxt_ptr` has priority over pop in the same cycle: `pop_rdy` = 0, and the requester holds the request.
- **LINK** (1 cycle):
  - If !`list_empty`: `nxt_mem[tail_ptr]` <= `alloc_ptr`.
  - Go TERM.
- **TERM** (1 cycle):
  - `nxt_mem[alloc_ptr]` <= NULL;
  - `tail_ptr` <= `alloc_ptr`;
  - if `list_empty`: `head_ptr` <= `alloc_ptr`;
  - `list_empty` <= 0;
  - `nxt_ptr_wr_done` <= 1;
  - go IDLE.
- **Latency and done semantics:**
  - `upd_nxt_ptr` at cycle T gives `nxt_ptr_wr_done` high at T+3.
  - `nxt_ptr_wr_done` stays high until the next accepted `upd_nxt_ptr`, so a late data-memory completion is never missed.
- `rd_nxt_ptr` updates every cycle from `rd_addr`. A write to the same address in cycle T is visible on a read issued at T+1.
- `free_cnt` changes by +1/-1 per push/pop. FIFO push and pop never coincide, because pop only happens in IDLE-upd and push only in INIT or IDLE-pop.
- The free FIFO wraps its read/write indices modulo 2**PTR_WD.
- `ptr_avail` = 0 when `free_cnt` == 0.
- The list holds at most NUM_NODES nodes; NULL is never allocated.

Decomposition:
- **Package `ll_pkg`:**
  - `PTR_WD`, `NULL_PTR`, `NUM_NODES`;
  - typedef `t_ptr`;
  - enum `t_ptr_srv_st` {INIT, IDLE, LINK, TERM}.
- **Sub-module `ll_free_ptr_fifo`:**
  - depth 2**PTR_WD, width PTR_WD;
  - push/pop/count/empty/full;
  - first-word-fall-through head output.
- Next-pointer memory and FSM stay in the top module.

Test Plan:
- Reset, release, wait → `init_done` rises after 15 cycles (PTR_WD=4); `free_cnt`=15, `nxt_ptr_from_servr`=0, `list_empty`=1.
- Three allocations with `cur_nxt_ptr`=0,1,2 → each `nxt_ptr_wr_done` at T+3; head=0, tail=2; reading `rd_addr`=0,1,2 gives 1,2,NULL; `free_cnt`=12.
- After the previous test, pop three times → head becomes 1, then 2, then NULL; `list_empty`=1; `free_cnt`=15; next served pointers are 3..14, then 0,1,2 (wrap).
- Allocate 15 nodes, then one more `upd_nxt_ptr` → `ptr_avail`=0 and `alloc_err` pulses; head/tail unchanged.
- `upd_nxt_ptr` and `pop_head_req` in the same cycle with a non-empty list → upd wins and `pop_rdy`=0; the held pop completes in the first IDLE cycle after TERM. Pop on an empty list → `pop_err` pulse.
- Assert `reset_n`=0 during LINK → after release, INIT re-runs; head/tail = NULL, `free_cnt` returns to 15, `nxt_ptr_wr_done`=0.
